bp_me_mem_responder: RTL

BP_ME_MEM_RESPONDER -- requirements
Module: bp_me_mem_responder

---
 rtl/bp_me_mem_responder_if.sv | 29 ++
 rtl/bp_me_mem_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/bp_me_mem_responder_if.sv
// ============================================================================
// Module   : bp_me_mem_responder_if
// Purpose  : Command/response channel between a CCE and the memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bp_me_mem_responder_if #(
    parameter int MSG_W = 575
);
    logic [MSG_W-1:0] mem_cmd_i;
    logic             mem_cmd_v_i;
    logic             mem_cmd_yumi_o;
    logic [MSG_W-1:0] mem_resp_o;
    logic             mem_resp_v_o;
    logic             mem_resp_ready_i;

    modport master (
        output mem_cmd_i, mem_cmd_v_i, mem_resp_ready_i,
        input  mem_cmd_yumi_o, mem_resp_o, mem_resp_v_o
    );

    modport slave (
        input  mem_cmd_i, mem_cmd_v_i, mem_resp_ready_i,
        output mem_cmd_yumi_o, mem_resp_o, mem_resp_v_o
    );
endinterface

`default_nettype wire

// File: rtl/bp_me_mem_responder.sv
// ============================================================================
// Module   : bp_me_mem_responder
// Purpose  : Fixed-latency block memory answering cached/uncached CCE commands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_me_mem_responder #(
    parameter int paddr_width_p   = 40,
    parameter int block_width_p   = 512,
    parameter int payload_width_p = 16,
    parameter int els_p           = 64,
    parameter int latency_p       = 4
) (
    input  wire logic            clk_i,
    input  wire logic            reset_i,
    bp_me_mem_responder_if.slave mem_if
);
    localparam int c_msg_w = 7 + paddr_width_p + payload_width_p + block_width_p;
    localparam int c_hdr_w = c_msg_w - block_width_p;
    localparam int c_bb    = block_width_p / 8;
    localparam int c_off_w = $clog2(c_bb);
    localparam int c_idx_w = $clog2(els_p);
    localparam int c_cnt_w = (latency_p > 1) ? $clog2(latency_p) : 1;

    localparam logic [1:0] c_st_ready = 2'd0;
    localparam logic [1:0] c_st_busy  = 2'd1;
    localparam logic [1:0] c_st_send  = 2'd2;

    localparam logic [c_off_w:0] c_one = 1;

    logic [1:0]               r_state;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [c_msg_w-1:0]       r_cmd;
    logic [block_width_p-1:0] r_resp_data;
    logic [block_width_p-1:0] r_mem [els_p];

    logic [3:0]               w_type;
    logic [2:0]               w_size;
    logic [c_idx_w-1:0]       w_idx;
    logic [c_off_w-1:0]       w_lo;
    logic [block_width_p-1:0] w_data;
    logic [block_width_p-1:0] w_blk;
    logic [2:0]               w_size_lg;
    logic [c_off_w:0]         w_nbytes;
    logic [c_off_w-1:0]       w_offset;
    logic [c_off_w+2:0]       w_shift;
    logic [c_bb-1:0]          w_bmask_lo;
    logic [c_bb-1:0]          w_bmask;
    logic [block_width_p-1:0] w_wdata_sh;
    logic [block_width_p-1:0] w_rdata_sh;
    logic [block_width_p-1:0] w_merged;
    logic [block_width_p-1:0] w_uc_rd;
    logic [block_width_p-1:0] w_rd_result;
    logic [block_width_p-1:0] w_wr_blk;
    logic                     w_wr_en;
    logic                     w_yumi;
    logic                     w_access;

    assign w_type = r_cmd[3:0];
    assign w_size = r_cmd[4+paddr_width_p +: 3];
    assign w_idx  = r_cmd[4+c_off_w +: c_idx_w];
    assign w_lo   = r_cmd[4 +: c_off_w];
    assign w_data = r_cmd[c_hdr_w +: block_width_p];
    assign w_blk  = r_mem[w_idx];

    // Uncached geometry: access size clamps to the block, offset aligns down to it
    assign w_size_lg  = (32'(w_size) > c_off_w) ? 3'(c_off_w) : w_size;
    assign w_nbytes   = c_one << w_size_lg;
    assign w_offset   = w_lo & ({c_off_w{1'b1}} << w_size_lg);
    assign w_shift    = {w_offset, 3'b000};
    assign w_bmask_lo = ~({c_bb{1'b1}} << w_nbytes);
    assign w_bmask    = w_bmask_lo << w_offset;
    assign w_wdata_sh = w_data << w_shift;
    assign w_rdata_sh = w_blk >> w_shift;

    always_comb begin
        w_merged    = w_blk;
        w_uc_rd     = '0;
        w_rd_result = '0;
        w_wr_blk    = w_blk;
        w_wr_en     = 1'b0;
        for (int b = 0; b < c_bb; b++) begin
            if (w_bmask[b])
                w_merged[8*b +: 8] = w_wdata_sh[8*b +: 8];
            if (w_bmask_lo[b])
                w_uc_rd[8*b +: 8] = w_rdata_sh[8*b +: 8];
        end
        case (w_type)
            4'd0: w_rd_result = w_blk;
            4'd1: begin
                w_wr_en  = 1'b1;
                w_wr_blk = w_data;
            end
            4'd2: w_rd_result = w_uc_rd;
            4'd3: begin
                w_wr_en  = 1'b1;
                w_wr_blk = w_merged;
            end
            default: w_rd_result = '0;
        endcase
    end

    assign w_yumi   = reset_i & mem_if.mem_cmd_v_i & (r_state == c_st_ready);
    assign w_access = (r_state == c_st_busy) && (r_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state     <= c_st_ready;
            r_cnt       <= '0;
            r_cmd       <= '0;
            r_resp_data <= '0;
            for (int i = 0; i < els_p; i++)
                r_mem[i] <= '0;
        end else begin
            case (r_state)
                c_st_ready: begin
                    if (w_yumi) begin
                        r_cmd   <= mem_if.mem_cmd_i;
                        r_cnt   <= c_cnt_w'(latency_p - 1);
                        r_state <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    if (w_access) begin
                        r_resp_data <= w_rd_result;
                        if (w_wr_en)
                            r_mem[w_idx] <= w_wr_blk;
                        r_state <= c_st_send;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_st_send: begin
                    if (mem_if.mem_resp_ready_i)
                        r_state <= c_st_ready;
                end
                default: r_state <= c_st_ready;
            endcase
        end
    end

    assign mem_if.mem_cmd_yumi_o = w_yumi;
    assign mem_if.mem_resp_v_o   = reset_i & (r_state == c_st_send);
    assign mem_if.mem_resp_o     = {r_resp_data, r_cmd[c_hdr_w-1:0]};

endmodule

`default_nettype wire
